// File: rtl/fir_mavg_pkg.sv
// Shared types and helpers for the multichannel boxcar moving-average filter.
package fir_mavg_pkg;

  typedef logic signed [23:0] sample_t;

  function automatic int acc_width(input int data_width, input int log2_taps);
    return data_width + log2_taps;
  endfunction

  // Clamp a wide signed value into the signed range of a dw-bit sample.
  function automatic logic signed [63:0] sat_to_sample(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_mavg_if.sv
// Sample stream, control and result signals between the codec FIFOs and the filter.
interface fir_mavg_if #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 24
);
  logic                           in_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] d;
  logic                           bypass;
  logic                           clear;
  logic [CHANNELS*DATA_WIDTH-1:0] q;
  logic                           out_valid;
  logic                           primed;

  modport master (output in_valid, d, bypass, clear, input q, out_valid, primed);
  modport slave  (input in_valid, d, bypass, clear, output q, out_valid, primed);
endinterface

// File: rtl/fir_mavg_multich_delay.sv
// Per-channel circular sample buffer; read is combinational and sees the pre-write contents.
module fir_delay_line #(
  parameter int DATA_WIDTH = 24,
  parameter int LOG2_TAPS  = 3
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [LOG2_TAPS-1:0]  ptr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] oldest
);
  localparam int TAPS = 1 << LOG2_TAPS;

  logic [DATA_WIDTH-1:0] mem_q [TAPS];
  logic [DATA_WIDTH-1:0] mem_d [TAPS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[ptr] = din;
  end

  // No reset: stale contents are masked by the shared fill count.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign oldest = mem_q[ptr];
endmodule

// File: rtl/fir_mavg_multich.sv
// CHANNELS-wide boxcar moving average with full-precision running sums and 1-cycle latency.
module fir_mavg_multich
  import fir_mavg_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int LOG2_TAPS  = 3,
  parameter int CHANNELS   = 2,
  parameter int ROUND      = 0
) (
  input logic       clock,
  input logic       reset,
  fir_mavg_if.slave bus
);
  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int AW   = acc_width(DATA_WIDTH, LOG2_TAPS);
  localparam logic [LOG2_TAPS:0] TAPS_C = (LOG2_TAPS + 1)'(TAPS);
  localparam logic signed [AW:0] RND_C =
    (ROUND != 0) ? ((AW + 1)'(1) << (LOG2_TAPS - 1)) : '0;

  logic [LOG2_TAPS-1:0]           ptr_q, ptr_d;
  logic [LOG2_TAPS:0]             fill_q, fill_d;
  logic signed [AW-1:0]           sum_q [CHANNELS];
  logic signed [AW-1:0]           sum_d [CHANNELS];
  logic [DATA_WIDTH-1:0]          oldest [CHANNELS];
  logic [CHANNELS*DATA_WIDTH-1:0] q_q, q_d;
  logic                           out_valid_q, out_valid_d;
  logic                           primed_q, primed_d;
  logic                           take;

  assign take = bus.in_valid && !bus.clear;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_line
    fir_delay_line #(.DATA_WIDTH(DATA_WIDTH), .LOG2_TAPS(LOG2_TAPS)) u_line (
      .clock  (clock),
      .we     (take),
      .ptr    (ptr_q),
      .din    (bus.d[c*DATA_WIDTH +: DATA_WIDTH]),
      .oldest (oldest[c])
    );
  end

  always_comb begin
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] old;
    logic signed [AW-1:0]  nxt;
    logic signed [AW:0]    g;
    logic signed [AW:0]    shifted;
    logic signed [63:0]    sat;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    q_d         = q_q;
    out_valid_d = take;
    din         = '0;
    old         = '0;
    nxt         = '0;
    g           = '0;
    shifted     = '0;
    sat         = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      din = bus.d[c*DATA_WIDTH +: DATA_WIDTH];
      old = (fill_q == TAPS_C) ? oldest[c] : '0;
      nxt = sum_q[c] + {{LOG2_TAPS{din[DATA_WIDTH-1]}}, din}
                     - {{LOG2_TAPS{old[DATA_WIDTH-1]}}, old};
      // Guard bit keeps the rounding add from wrapping at full scale.
      g       = {nxt[AW-1], nxt} + RND_C;
      shifted = g >>> LOG2_TAPS;
      sat     = sat_to_sample(64'(shifted), DATA_WIDTH);
      sum_d[c] = bus.clear ? '0 : (take ? nxt : sum_q[c]);
      if (take) q_d[c*DATA_WIDTH +: DATA_WIDTH] = bus.bypass ? din : sat[DATA_WIDTH-1:0];
    end
    if (bus.clear) begin
      ptr_d  = '0;
      fill_d = '0;
    end else if (take) begin
      ptr_d = ptr_q + LOG2_TAPS'(1);
      if (fill_q != TAPS_C) fill_d = fill_q + (LOG2_TAPS + 1)'(1);
    end
    primed_d = (fill_d == TAPS_C);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q       <= '0;
      fill_q      <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) sum_q[c] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
      primed_q    <= primed_d;
      for (int c = 0; c < CHANNELS; c++) sum_q[c] <= sum_d[c];
    end
  end

  assign bus.q         = q_q;
  assign bus.out_valid = out_valid_q;
  assign bus.primed    = primed_q;
endmodule

// File: tb/tb_fir_mavg_multich.sv
// Directed bench: truncating (u0) and rounding (u1) 4-tap filters driven with identical stimulus.
module tb_fir_mavg_multich;
  localparam int DW = 24;
  localparam int CH = 2;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  fir_mavg_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) if0 ();
  fir_mavg_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) if1 ();

  fir_mavg_multich #(.DATA_WIDTH(DW), .LOG2_TAPS(2), .CHANNELS(CH), .ROUND(0)) u0 (
    .clock (clock), .reset (reset), .bus (if0.slave));
  fir_mavg_multich #(.DATA_WIDTH(DW), .LOG2_TAPS(2), .CHANNELS(CH), .ROUND(1)) u1 (
    .clock (clock), .reset (reset), .bus (if1.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit     rst_before;
    longint d0, d1;
    longint e0_q0, e0_q1;
    longint e1_q0, e1_q1;
    bit     primed;
  } vec_t;

  vec_t vecs[10];

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit iv, input longint a, input longint b, input bit byp, input bit clr);
    if0.in_valid = iv;  if1.in_valid = iv;
    if0.d = {DW'(b), DW'(a)};
    if1.d = {DW'(b), DW'(a)};
    if0.bypass = byp;   if1.bypass = byp;
    if0.clear  = clr;   if1.clear  = clr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].rst_before) do_reset();
      drive(1, vecs[i].d0, vecs[i].d1, 0, 0);
      step();
      chk($sformatf("vec%0d u0.q0", i), sx(if0.q[DW-1:0]), vecs[i].e0_q0);
      chk($sformatf("vec%0d u0.q1", i), sx(if0.q[2*DW-1:DW]), vecs[i].e0_q1);
      chk($sformatf("vec%0d u1.q0", i), sx(if1.q[DW-1:0]), vecs[i].e1_q0);
      chk($sformatf("vec%0d u1.q1", i), sx(if1.q[2*DW-1:DW]), vecs[i].e1_q1);
      chk($sformatf("vec%0d out_valid", i), longint'(if0.out_valid), 1);
      chk($sformatf("vec%0d primed", i), longint'(if0.primed), longint'(vecs[i].primed));
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    longint ramp_q[5];
    longint fs, fs_exp;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    drive(0, 0, 0, 0, 0);

    // 400/-400 ramp (both rounding modes agree), then 1s on ch0 where rounding differs
    vecs[0] = '{1'b0, 400, -400, 100, -100, 100, -100, 1'b0};
    vecs[1] = '{1'b0, 400, -400, 200, -200, 200, -200, 1'b0};
    vecs[2] = '{1'b0, 400, -400, 300, -300, 300, -300, 1'b0};
    vecs[3] = '{1'b0, 400, -400, 400, -400, 400, -400, 1'b1};
    vecs[4] = '{1'b0, 400, -400, 400, -400, 400, -400, 1'b1};
    vecs[5] = '{1'b0, 400, -400, 400, -400, 400, -400, 1'b1};
    vecs[6] = '{1'b1, 1, 0, 0, 0, 0, 0, 1'b0};
    vecs[7] = '{1'b0, 1, 0, 0, 0, 1, 0, 1'b0};
    vecs[8] = '{1'b0, 1, 0, 0, 0, 1, 0, 1'b0};
    vecs[9] = '{1'b0, 1, 0, 1, 0, 1, 0, 1'b1};
    ramp_q = '{1, 3, 6, 10, 14};

    do_reset();
    chk("reset q", longint'(if0.q), 0);
    chk("reset out_valid", longint'(if0.out_valid), 0);
    chk("reset primed", longint'(if0.primed), 0);
    step();
    chk("idle out_valid", longint'(if1.out_valid), 0);

    run_vec(0, 5);

    // reset mid-stream with a sample present, then the same stream must repeat exactly
    drive(1, 400, -400, 0, 0);
    step();
    reset = 1'b0;
    drive(1, 123, 456, 0, 0);
    step();
    reset = 1'b1;
    chk("midrst q", longint'(if0.q), 0);
    chk("midrst out_valid", longint'(if0.out_valid), 0);
    chk("midrst primed", longint'(if0.primed), 0);
    run_vec(0, 5);

    run_vec(6, 9);

    // sparse input: one sample every third cycle, q holds between pulses
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 4 * (i + 1), 0, 0, 0);
      step();
      chk($sformatf("sparse%0d q", i), sx(if0.q[DW-1:0]), ramp_q[i]);
      chk($sformatf("sparse%0d ov", i), longint'(if0.out_valid), 1);
      drive(0, 999, 999, 0, 0);
      step();
      chk($sformatf("sparse%0d ov_low", i), longint'(if0.out_valid), 0);
      step();
      chk($sformatf("sparse%0d hold", i), sx(if0.q[DW-1:0]), ramp_q[i]);
    end

    // full scale with rounding, then decay to zero
    do_reset();
    fs = 8388607;
    for (int i = 1; i <= 8; i++) begin
      drive(1, fs, -fs - 1, 0, 0);
      step();
      fs_exp = ((i < 4 ? i : 4) * fs + 2) >>> 2;
      chk($sformatf("fs%0d u1.q0", i), sx(if1.q[DW-1:0]), fs_exp);
      fs_exp = ((i < 4 ? i : 4) * (-fs - 1) + 2) >>> 2;
      chk($sformatf("fs%0d u1.q1", i), sx(if1.q[2*DW-1:DW]), fs_exp);
    end
    chk("fs u0.q0", sx(if0.q[DW-1:0]), 8388607);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 0, 0);
      step();
      if (i == 3) chk("decay3 u1.q0", sx(if1.q[DW-1:0]), 2097152);
    end
    chk("decay4 u1.q0", sx(if1.q[DW-1:0]), 0);
    chk("decay4 u1.q1", sx(if1.q[2*DW-1:DW]), 0);

    // clear discards a coincident sample; bypass keeps the window updating
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 400, 0, 0, 0);
      step();
    end
    chk("pre-clear primed", longint'(if0.primed), 1);
    drive(1, 999, 0, 0, 1);
    step();
    chk("clear ov", longint'(if0.out_valid), 0);
    chk("clear primed", longint'(if0.primed), 0);
    chk("clear q hold", sx(if0.q[DW-1:0]), 400);
    drive(1, 800, 0, 0, 0);
    step();
    chk("post-clear q1", sx(if0.q[DW-1:0]), 200);
    chk("post-clear primed1", longint'(if0.primed), 0);
    step();
    chk("post-clear q2", sx(if0.q[DW-1:0]), 400);
    drive(1, 800, 0, 1, 0);
    step();
    chk("bypass q3", sx(if0.q[DW-1:0]), 800);
    chk("bypass primed3", longint'(if0.primed), 0);
    step();
    chk("bypass q4", sx(if0.q[DW-1:0]), 800);
    chk("bypass primed4", longint'(if0.primed), 1);
    drive(1, 800, 0, 0, 0);
    step();
    chk("unbypass q5", sx(if0.q[DW-1:0]), 800);
    drive(1, 0, 0, 0, 0);
    step();
    chk("unbypass q6", sx(if0.q[DW-1:0]), 600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_mavg_multich.md
Name: fir_mavg_multich

Overview:
Parametrised successor to the single-channel moving-average FIR in the audio path. It filters CHANNELS independent signed sample streams (e.g. codec L/R) with a 2^LOG2_TAPS-tap boxcar average. Each channel keeps a full-precision running sum, so the previous pre-shift truncation error is gone. Adds a sample-valid handshake, a primed flag, optional rounding, runtime bypass and a synchronous clear. Sits between the codec input FIFO and the codec output FIFO.

Parameters:
DATA_WIDTH, 24, sample width, two's complement
LOG2_TAPS, 3, window length TAPS = 2^LOG2_TAPS (1..10)
CHANNELS, 2, number of parallel channels sharing one in_valid
ROUND, 0, 1 = round-half-up (add 2^(LOG2_TAPS-1) before shift); 0 = arithmetic-shift truncate

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  one sample per channel presented this cycle
d  in  CHANNELS x DATA_WIDTH  signed input samples, channel 0 in the LSBs
bypass  in  1  1 = q carries registered d; filter state still updates
clear  in  1  synchronous flush of window and sums (reset-like, ports stay live)
q  out  CHANNELS x DATA_WIDTH  signed filtered samples
out_valid  out  1  q updated this cycle
primed  out  1  window holds TAPS real samples

Behaviour:
- Reset (reset==0 at clock edge): q=0, out_valid=0, primed=0, all sums=0, write pointer=0, fill count=0. Delay-line memory is not cleared; the fill count masks stale contents.
- Per channel, sum width is DATA_WIDTH+LOG2_TAPS, signed. On in_valid: oldest = (fill<TAPS) ? 0 : line[ptr]; sum_next = sum + sext(d) - sext(oldest); line[ptr] <= d; ptr <= ptr+1, wrapping TAPS-1 -> 0; fill increments and saturates at TAPS.
- Output: avg = (sum_next + (ROUND ? 2^(LOG2_TAPS-1) : 0)) >>> LOG2_TAPS. Use an extra guard bit for the rounding add. Saturate to the DATA_WIDTH signed range; only rounding at full scale can exceed it.
- Latency: exactly 1 cycle. in_valid at edge k gives q and out_valid=1 after edge k (held for one cycle). q holds its value while in_valid==0; out_valid=0.
- bypass==1: q <= d on in_valid. Sums, pointer and fill still update, so deasserting bypass gives a correct average immediately. Sampled at the in_valid cycle only.
- primed: 1 from the output cycle of the TAPS-th sample after reset/clear. Before that, the output is the sum of the samples so far divided by TAPS (ramp-up), not a partial mean.
- clear==1: sums, ptr, fill, primed <= 0; out_valid <= 0; q holds. clear has priority over in_valid; a coincident sample is discarded.
- reset low mid-stream: identical to power-up reset. Next in_valid is treated as sample #1.
- No back-pressure: one sample per cycle sustained throughput; in_valid may be high every cycle.
- Delay line read uses the pre-write address in the same cycle (read-before-write). Memory may infer registers or MLAB; combinational read required.

Decomposition:
- Package fir_mavg_pkg: sample_t (signed DATA_WIDTH), function acc_width(DATA_WIDTH, LOG2_TAPS), function sat_to_sample.
- Sub-module fir_delay_line (one instance per channel): circular buffer, DATA_WIDTH x TAPS. Takes shared ptr and write enable; returns oldest. Pointer, fill counter and primed are shared in the top-level module, not per channel.

Test Plan:
- DATA_WIDTH=24, LOG2_TAPS=2, ROUND=0; ch0=+400, ch1=-400, in_valid every cycle for 6 samples -> ch0 q=100,200,300,400,400,400; ch1 -100..-400,-400,-400; primed rises with the 4th out_valid.
- Same config, ch0 = 1 for 4 samples -> ROUND=0: 0,0,0,1; ROUND=1: 0,1,1,1.
- in_valid every 3rd cycle, ch0 ramp 4,8,12,16,20 -> out_valid pulses one cycle after each in_valid; q=1,3,6,10,14 and holds between pulses.
- Full scale: ch0=0x7FFFFF, ch1=0x800000 for 8 samples, LOG2_TAPS=2, ROUND=1 -> settles at 0x7FFFFF / 0x800000, no wrap; window then switched to 0 decays to 0 in 4 samples.
- After primed with ch0=400: assert clear with in_valid=1, then feed 800 -> first q=200, primed=0 until the 4th new sample; bypass=1 for 2 samples gives q=800,800, then bypass=0 gives q=800 (window full of 800).
- reset low for 1 cycle mid-stream (during in_valid) -> next cycle q=0, out_valid=0, primed=0; restarting test 1 stimulus reproduces the same sequence exactly.
